// File: rtl/sata_oob_detect_if.sv
// Receive-side OOB signalling bundle: electrical-idle input and the two
// single-cycle detection pulses.
interface sata_oob_detect_if;
    logic i_idle;
    logic o_cominit;
    logic o_comwake;

    modport master (output i_idle, input  o_cominit, input  o_comwake);
    modport slave  (input  i_idle, output o_cominit, output o_comwake);
endinterface

// File: rtl/sata_oob_detect.sv
// SATA OOB classifier: measures burst/gap run lengths on the electrical-idle
// line and pulses o_cominit or o_comwake after NBURSTS valid bursts.
module sata_oob_detect #(
    parameter int unsigned MIN_BURST    = 10,
    parameter int unsigned MAX_BURST    = 24,
    parameter int unsigned MIN_WAKE_GAP = 8,
    parameter int unsigned MAX_WAKE_GAP = 26,
    parameter int unsigned MIN_INIT_GAP = 27,
    parameter int unsigned MAX_INIT_GAP = 79,
    parameter int unsigned NBURSTS      = 4,
    parameter int unsigned LGCOUNT      = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    sata_oob_detect_if.slave   bus
);

    localparam int unsigned NBW = $clog2(NBURSTS + 1);

    localparam logic [LGCOUNT-1:0] C_ZERO         = LGCOUNT'(0);
    localparam logic [LGCOUNT-1:0] C_ONE          = LGCOUNT'(1);
    localparam logic [LGCOUNT-1:0] C_MIN_BURST    = LGCOUNT'(MIN_BURST);
    localparam logic [LGCOUNT-1:0] C_MAX_BURST    = LGCOUNT'(MAX_BURST);
    localparam logic [LGCOUNT-1:0] C_BURST_SAT    = LGCOUNT'(MAX_BURST + 1);
    localparam logic [LGCOUNT-1:0] C_MIN_WAKE_GAP = LGCOUNT'(MIN_WAKE_GAP);
    localparam logic [LGCOUNT-1:0] C_MAX_WAKE_GAP = LGCOUNT'(MAX_WAKE_GAP);
    localparam logic [LGCOUNT-1:0] C_MIN_INIT_GAP = LGCOUNT'(MIN_INIT_GAP);
    localparam logic [LGCOUNT-1:0] C_MAX_INIT_GAP = LGCOUNT'(MAX_INIT_GAP);

    localparam logic [NBW-1:0] C_NB_ZERO = NBW'(0);
    localparam logic [NBW-1:0] C_NB_ONE  = NBW'(1);
    localparam logic [NBW-1:0] C_NB_LAST = NBW'(NBURSTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;
    typedef enum logic [1:0] {CLS_NONE, CLS_WAKE, CLS_INIT} cls_t;

    state_t               r_state, w_state;
    logic [LGCOUNT-1:0]   r_count, w_count;
    logic [NBW-1:0]       r_nb, w_nb;
    cls_t                 r_cls, w_cls;
    logic                 r_cominit, w_cominit;
    logic                 r_comwake, w_comwake;

    logic                 w_idle;
    logic                 w_burst_ok;
    cls_t                 w_gap_cls;
    cls_t                 w_cls_sel;
    logic                 w_gap_match;

    assign w_idle     = bus.i_idle;
    assign w_burst_ok = (r_count >= C_MIN_BURST) && (r_count <= C_MAX_BURST);

    // Gap classification; the first gap of a sequence defines the class.
    always_comb begin
        w_gap_cls = CLS_NONE;
        if ((r_count >= C_MIN_WAKE_GAP) && (r_count <= C_MAX_WAKE_GAP))
            w_gap_cls = CLS_WAKE;
        else if ((r_count >= C_MIN_INIT_GAP) && (r_count <= C_MAX_INIT_GAP))
            w_gap_cls = CLS_INIT;
    end

    assign w_cls_sel   = (r_nb == C_NB_ONE) ? w_gap_cls : r_cls;
    assign w_gap_match = (w_gap_cls != CLS_NONE) && (w_gap_cls == w_cls_sel);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_count   <= C_ZERO;
            r_nb      <= C_NB_ZERO;
            r_cls     <= CLS_NONE;
            r_cominit <= 1'b0;
            r_comwake <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_count   <= w_count;
            r_nb      <= w_nb;
            r_cls     <= w_cls;
            r_cominit <= w_cominit;
            r_comwake <= w_comwake;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_count   = r_count;
        w_nb      = r_nb;
        w_cls     = r_cls;
        w_cominit = 1'b0;
        w_comwake = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_idle) begin
                    w_state = S_BURST;
                    w_count = C_ONE;
                end
            end

            S_BURST: begin
                if (!w_idle) begin
                    if (r_count != C_BURST_SAT)
                        w_count = r_count + C_ONE;
                end else if (w_burst_ok && (r_nb == C_NB_LAST)) begin
                    w_cominit = (r_cls == CLS_INIT);
                    w_comwake = (r_cls == CLS_WAKE);
                    w_state   = S_IDLE;
                    w_count   = C_ZERO;
                    w_nb      = C_NB_ZERO;
                    w_cls     = CLS_NONE;
                end else if (w_burst_ok) begin
                    w_nb    = r_nb + C_NB_ONE;
                    w_state = S_GAP;
                    w_count = C_ONE;
                end else begin
                    w_state = S_IDLE;
                    w_count = C_ZERO;
                    w_nb    = C_NB_ZERO;
                    w_cls   = CLS_NONE;
                end
            end

            S_GAP: begin
                if (w_idle) begin
                    // Idle past the longest init gap abandons the sequence.
                    if (r_count >= C_MAX_INIT_GAP) begin
                        w_state = S_IDLE;
                        w_count = C_ZERO;
                        w_nb    = C_NB_ZERO;
                        w_cls   = CLS_NONE;
                    end else begin
                        w_count = r_count + C_ONE;
                    end
                end else if (w_gap_match) begin
                    w_state = S_BURST;
                    w_count = C_ONE;
                    w_cls   = w_cls_sel;
                end else begin
                    // Bad gap: this burst becomes the first of a new sequence.
                    w_state = S_BURST;
                    w_count = C_ONE;
                    w_nb    = C_NB_ZERO;
                    w_cls   = CLS_NONE;
                end
            end

            default: begin
                w_state = S_IDLE;
                w_count = C_ZERO;
                w_nb    = C_NB_ZERO;
                w_cls   = CLS_NONE;
            end
        endcase
    end

    assign bus.o_cominit = r_cominit;
    assign bus.o_comwake = r_comwake;

endmodule

// File: tb/tb_sata_oob_detect.sv
// Directed bench for sata_oob_detect: drives burst/gap patterns on i_idle
// and counts pulse occurrences, widths and latency.
module tb_sata_oob_detect;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sata_oob_detect_if bus();

    sata_oob_detect dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int n_init, n_wake, n_both, n_long;
    int init_at, wake_at, end_at;
    logic prev_i = 1'b0;
    logic prev_w = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: apply i_idle, then observe the registered outputs.
    task automatic cyc(input logic v);
        bus.i_idle = v;
        @(posedge clk);
        #1;
        cyc_n++;
        if (bus.o_cominit === 1'b1) begin
            n_init++;
            init_at = cyc_n;
            if (prev_i) n_long++;
        end
        if (bus.o_comwake === 1'b1) begin
            n_wake++;
            wake_at = cyc_n;
            if (prev_w) n_long++;
        end
        if ((bus.o_cominit === 1'b1) && (bus.o_comwake === 1'b1)) n_both++;
        prev_i = (bus.o_cominit === 1'b1);
        prev_w = (bus.o_comwake === 1'b1);
    endtask

    task automatic clr();
        n_init = 0; n_wake = 0; n_both = 0; n_long = 0;
        init_at = -1; wake_at = -1; end_at = -2;
    endtask

    task automatic burst(input int n);
        repeat (n) cyc(1'b0);
    endtask

    task automatic gap(input int n);
        repeat (n) cyc(1'b1);
    endtask

    task automatic bg(input int b, input int g);
        burst(b);
        gap(g);
    endtask

    // Final burst: the idle sample ending it is the latency reference.
    task automatic last_burst(input int b);
        burst(b);
        cyc(1'b1);
        end_at = cyc_n;
        gap(100);
    endtask

    task automatic seq4(input int b0, input int b1, input int b2, input int b3, input int g);
        bg(b0, g);
        bg(b1, g);
        bg(b2, g);
        last_burst(b3);
    endtask

    task automatic result(input string tag, input int ei, input int ew);
        check({tag, " cominit_count"}, n_init, ei);
        check({tag, " comwake_count"}, n_wake, ew);
        check({tag, " overlap"}, n_both, 0);
        check({tag, " wide_pulse"}, n_long, 0);
        if (ei == 1) check({tag, " cominit_latency"}, init_at, end_at);
        if (ew == 1) check({tag, " comwake_latency"}, wake_at, end_at);
    endtask

    // Two valid bursts, then a disruptor, then four fresh bursts needed.
    task automatic restart_test(input string tag, input int bad_b, input int bad_g);
        clr();
        bg(16, 48);
        bg(16, 48);
        bg(bad_b, bad_g);
        bg(16, 48);
        bg(16, 48);
        bg(16, 48);
        check({tag, " early"}, n_init + n_wake, 0);
        last_burst(16);
        result(tag, 1, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_idle = 1'b0;
        clr();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0);
            check("reset cominit", int'(bus.o_cominit), 0);
            check("reset comwake", int'(bus.o_comwake), 0);
        end
        rst = 1'b0;
        gap(5);

        clr(); seq4(16, 16, 16, 16, 48); result("init", 1, 0);
        clr(); seq4(16, 16, 16, 16, 16); result("wake", 0, 1);
        clr(); seq4(10, 24, 10, 24, 48); result("burst_10_24", 1, 0);
        clr(); seq4(16, 16, 16, 16, 79); result("gap_79", 1, 0);
        clr(); seq4(16, 16, 16, 16, 27); result("gap_27", 1, 0);
        clr(); seq4(24, 10, 24, 10, 26); result("gap_26", 0, 1);
        clr(); seq4(16, 16, 16, 16, 8);  result("gap_8", 0, 1);

        // Class mismatch on gap 2 restarts counting from burst 3.
        clr();
        bg(16, 48);
        bg(16, 16);
        bg(16, 48);
        bg(16, 48);
        check("mixed early", n_init + n_wake, 0);
        bg(16, 48);
        last_burst(16);
        result("mixed", 1, 0);

        restart_test("burst_9", 9, 48);
        restart_test("burst_25", 25, 48);
        restart_test("gap_80", 16, 80);
        restart_test("gap_7", 16, 7);

        // Reset in the gap after burst 3 discards progress.
        clr();
        bg(16, 48);
        bg(16, 48);
        burst(16);
        gap(10);
        rst = 1'b1;
        cyc(1'b1);
        check("midreset cominit", int'(bus.o_cominit), 0);
        check("midreset comwake", int'(bus.o_comwake), 0);
        rst = 1'b0;
        gap(37);
        burst(16);
        gap(100);
        result("midreset", 0, 0);

        clr();
        seq4(16, 16, 16, 16, 48);
        seq4(16, 16, 16, 16, 48);
        result("back_to_back", 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
